// File: rtl/bus_if_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_if_if
// Description : System-bus signal bundle between bus_if (master) and the bus.
//               bus_err exists only when BUS_IF_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_if_if;
    logic        bus_req_;
    logic        bus_grant_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
`ifdef BUS_IF_TIMEOUT_EN
    logic        bus_err;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_err,
        input  bus_grant_, bus_rd_data, bus_rdy_
    );
    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_err,
        output bus_grant_, bus_rd_data, bus_rdy_
    );
`else
    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_grant_, bus_rd_data, bus_rdy_
    );
    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_grant_, bus_rd_data, bus_rdy_
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bus_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_if
// Description : Pipeline-side bus interface unit: arbitrates for the system
//               bus, runs one transfer with wait states, returns read data.
//               Optional ready timeout enabled by macro BUS_IF_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] addr,
    input  logic        as_,
    input  logic        rw,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    bus_if_if.master    bus
);

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("bus_if: TIMEOUT_CYCLES must be within 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_bus_req_;
    logic        r_bus_as_;
    logic        r_bus_rw;
    logic [29:0] r_bus_addr;
    logic [31:0] r_bus_wr_data;
    logic [31:0] r_rd_buf;

    logic        w_ready;
    logic        w_abort;
    logic        w_done;

    // Ready is only meaningful in ACCESS; a ready seen during REQ is ignored.
    assign w_ready = (r_state == ST_ACCESS) && !bus.bus_rdy_;

`ifdef BUS_IF_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_bus_err;

    // Abort on the ACCESS cycle whose increment would reach the limit.
    assign w_abort = (r_state == ST_ACCESS) && bus.bus_rdy_ && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (r_state == ST_REQ) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_state == ST_ACCESS && bus.bus_rdy_) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    assign w_abort = 1'b0;
`endif

    assign w_done = w_ready || w_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bus_req_    <= 1'b1;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= 1'b1;
            r_bus_addr    <= 30'd0;
            r_bus_wr_data <= 32'd0;
            r_rd_buf      <= 32'd0;
        end else begin
            r_bus_as_ <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!as_ && !flush) begin
                        r_bus_req_    <= 1'b0;
                        r_bus_addr    <= addr;
                        r_bus_rw      <= rw;
                        r_bus_wr_data <= wr_data;
                        r_state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus.bus_grant_) begin
                        r_bus_as_ <= 1'b0;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_bus_req_ <= 1'b1;
                        r_rd_buf   <= w_abort ? 32'd0 : bus.bus_rd_data;
                        r_state    <= stall ? ST_STALL : ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (!stall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // busy drops in the completion cycle itself so the pipeline can advance.
    always_comb begin
        busy    = 1'b0;
        rd_data = 32'd0;
        case (r_state)
            ST_IDLE:   busy = !as_ && !flush;
            ST_REQ:    busy = 1'b1;
            ST_ACCESS: begin
                busy = !w_done;
                if (w_ready && r_bus_rw) begin
                    rd_data = bus.bus_rd_data;
                end
            end
            ST_STALL:  rd_data = r_rd_buf;
            default:   busy = 1'b0;
        endcase
    end

    assign bus.bus_req_    = r_bus_req_;
    assign bus.bus_as_     = r_bus_as_;
    assign bus.bus_rw      = r_bus_rw;
    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_wr_data = r_bus_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_if
// Description : Self-checking bench for bus_if: table vectors, randomized
//               transfers against a transaction-level model, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_if;

    localparam int c_TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    bus_if_if bif ();

    bus_if #(.TIMEOUT_CYCLES(c_TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .busy    (busy),
        .addr    (addr),
        .as_     (as_),
        .rw      (rw),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          gw;
        int          rdw;
        int          stl;
        int          exp_busy;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        as_             = 1'b1;
        flush           = 1'b0;
        stall           = 1'b0;
        rw              = 1'b1;
        addr            = 30'd0;
        wr_data         = 32'd0;
        bif.bus_grant_  = 1'b1;
        bif.bus_rdy_    = 1'b1;
        bif.bus_rd_data = 32'd0;
    endtask

    // Drives one transfer cycle by cycle; cycle 0 is the strobe, e is the ready cycle.
    task automatic run_txn(input vec_t v, input bit rnd);
        int          e;
        int          last;
        int          n_busy;
        int          bad_req;
        int          bad_as;
        int          bad_rd;
        int          bad_hold;
        logic        exp_req;
        logic        exp_as;
        logic [31:0] exp_rd;
        e        = 2 + v.gw + v.rdw;
        last     = e + v.stl + 1;
        n_busy   = 0;
        bad_req  = 0;
        bad_as   = 0;
        bad_rd   = 0;
        bad_hold = 0;
        for (int c = 0; c <= last; c++) begin
            as_ = (c == 0 || (c > e && c <= e + v.stl)) ? 1'b0 : 1'b1;
            if (c == 0) begin
                rw      = v.rw;
                addr    = v.addr;
                wr_data = v.wd;
            end else begin
                rw      = 1'($urandom_range(0, 1));
                addr    = 30'($urandom);
                wr_data = $urandom;
            end
            flush          = (rnd && c >= 1 && c <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
            bif.bus_grant_ = (c == 1 + v.gw) ? 1'b0 : 1'b1;
            if (c >= 1 && c <= 1 + v.gw) begin
                bif.bus_rdy_ = 1'($urandom_range(0, 1));
            end else begin
                bif.bus_rdy_ = (c == e) ? 1'b0 : 1'b1;
            end
            bif.bus_rd_data = (c == e) ? v.rdata : $urandom;
            if (c >= e && c < e + v.stl) begin
                stall = 1'b1;
            end else if (rnd && c < e) begin
                stall = 1'($urandom_range(0, 1));
            end else begin
                stall = 1'b0;
            end
            #3;
            exp_req = (c >= 1 && c <= e) ? 1'b0 : 1'b1;
            exp_as  = (c == 2 + v.gw) ? 1'b0 : 1'b1;
            if (c == e) begin
                exp_rd = v.exp_rd;
            end else if (c > e && c <= e + v.stl) begin
                exp_rd = v.rdata;
            end else begin
                exp_rd = 32'd0;
            end
            if (busy === 1'b1) n_busy++;
            if (bif.bus_req_ !== exp_req) bad_req++;
            if (bif.bus_as_ !== exp_as) bad_as++;
            if (rd_data !== exp_rd) bad_rd++;
            if (c >= 1 && c <= e + v.stl &&
                (bif.bus_addr !== v.addr || bif.bus_rw !== v.rw || bif.bus_wr_data !== v.wd))
                bad_hold++;
`ifdef BUS_IF_TIMEOUT_EN
            if (bif.bus_err !== 1'b0) bad_hold++;
`endif
            @(posedge clk);
            #1;
        end
        check("busy_cycles", n_busy, v.exp_busy);
        check("req_bad_cycles", bad_req, 0);
        check("as_bad_cycles", bad_as, 0);
        check("rd_data_bad_cycles", bad_rd, 0);
        check("bus_hold_bad_cycles", bad_hold, 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int   n_busy;
        int   err_at;

        tbl[0] = '{1'b1, 30'h0000100,  32'h0,        32'hDEADBEEF, 0, 0, 0, 2, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 30'h0ABCDEF,  32'h12345678, 32'h55AA55AA, 0, 3, 0, 5, 32'h0};
        tbl[2] = '{1'b1, 30'h3FFFFFFF, 32'h0,        32'h0F0F0F0F, 4, 0, 0, 6, 32'h0F0F0F0F};
        tbl[3] = '{1'b1, 30'h0002000,  32'h0,        32'hCAFEF00D, 0, 0, 3, 2, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 30'h1234567,  32'hFFFFFFFF, 32'hA5A5A5A5, 2, 1, 2, 5, 32'h0};
        tbl[5] = '{1'b1, 30'h0000000,  32'h0,        32'h00000000, 1, 2, 1, 5, 32'h0};

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
        check("rst_bus_as_", {31'd0, bif.bus_as_}, 32'd1);
        check("rst_bus_rw", {31'd0, bif.bus_rw}, 32'd1);
        check("rst_bus_addr", {2'd0, bif.bus_addr}, 32'd0);
        check("rst_bus_wr_data", bif.bus_wr_data, 32'd0);
`ifdef BUS_IF_TIMEOUT_EN
        check("rst_bus_err", {31'd0, bif.bus_err}, 32'd0);
`endif
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i], 1'b0);
        end

        // Flush with a strobe in IDLE must not start a transfer.
        as_   = 1'b0;
        flush = 1'b1;
        #3;
        check("flush_busy", {31'd0, busy}, 32'd0);
        step();
        as_   = 1'b1;
        flush = 1'b0;
        #3;
        check("flush_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
        check("flush_busy_next", {31'd0, busy}, 32'd0);
        step();

        // Reset while waiting for ready abandons the transfer.
        as_  = 1'b0;
        rw   = 1'b1;
        addr = 30'h123;
        step();
        as_            = 1'b1;
        bif.bus_grant_ = 1'b0;
        step();
        bif.bus_grant_ = 1'b1;
        #3;
        check("access_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #3;
        check("rstmid_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_bus_addr", {2'd0, bif.bus_addr}, 32'd0);
        step();
        bif.bus_rdy_    = 1'b0;
        bif.bus_rd_data = 32'h11112222;
        #3;
        check("rstmid_rd_data", rd_data, 32'd0);
        step();
        idle_inputs();
        step();

`ifdef BUS_IF_TIMEOUT_EN
        // Ready never arrives: abort on the 4th ACCESS cycle, error pulse next.
        n_busy = 0;
        err_at = -1;
        for (int c = 0; c <= 7; c++) begin
            as_            = (c == 0) ? 1'b0 : 1'b1;
            rw             = 1'b1;
            bif.bus_grant_ = (c == 1) ? 1'b0 : 1'b1;
            bif.bus_rdy_   = 1'b1;
            bif.bus_rd_data = 32'hBAD0BAD0;
            #3;
            if (busy === 1'b1) n_busy++;
            if (bif.bus_err === 1'b1) begin
                if (err_at < 0) err_at = c;
                else err_at = 100;
            end
            if (c == 5) check("tmo_rd_data", rd_data, 32'd0);
            if (c == 6) check("tmo_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
            step();
        end
        check("tmo_busy_cycles", n_busy, 32'd5);
        check("tmo_err_cycle", err_at, 32'd6);
        idle_inputs();
        step();
`endif

        for (int i = 0; i < 40; i++) begin
            rv.rw       = 1'($urandom_range(0, 1));
            rv.addr     = 30'($urandom);
            rv.wd       = $urandom;
            rv.rdata    = $urandom;
            rv.gw       = int'($urandom_range(0, 5));
            rv.rdw      = int'($urandom_range(0, 3));
            rv.stl      = int'($urandom_range(0, 3));
            rv.exp_busy = 2 + rv.gw + rv.rdw;
            rv.exp_rd   = rv.rw ? rv.rdata : 32'd0;
            run_txn(rv, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_if.md
# bus_if

Pipeline-side bus interface unit downstream of the MEM-stage memory controller. It takes the controller's word address, active-low strobe, read/write select and write data. It arbitrates for the shared system bus, runs one transfer with wait states, and returns read data. While a transfer is in flight it raises `busy` so the pipeline stalls.

## Interface
- `TIMEOUT_CYCLES`, 255: ready-timeout limit in cycles; used only with `BUS_IF_TIMEOUT_EN`; range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  pipeline stall; holds a completed result.
- `flush`  in  1  pipeline flush; suppresses a new access in IDLE.
- `busy`  out  1  transfer in progress; the pipeline must stall.
- `addr`  in  30  word address from the memory controller.
- `as_`  in  1  access strobe, active-low (0 = request).
- `rw`  in  1  1 = read, 0 = write.
- `wr_data`  in  32  store data.
- `rd_data`  out  32  load data returned to the memory controller.
- `bus_req_`  out  1  bus request, active-low.
- `bus_grant_`  in  1  bus grant, active-low.
- `bus_addr`  out  30  bus word address.
- `bus_as_`  out  1  bus address strobe, active-low.
- `bus_rw`  out  1  bus read/write (1 = read).
- `bus_wr_data`  out  32  bus write data.
- `bus_rd_data`  in  32  bus read data.
- `bus_rdy_`  in  1  slave ready, active-low.
- `bus_err`  out  1  timeout abort pulse; present only with `BUS_IF_TIMEOUT_EN`.

## Operation
- States: IDLE, REQ, ACCESS, STALL (2-bit encoded).
- Reset state: state = IDLE, `bus_req_` = 1, `bus_as_` = 1, `bus_rw` = 1, `bus_addr` = 0, `bus_wr_data` = 0, `rd_buf` = 0, `bus_err` = 0.
- Reset output values: `busy` = 0, `rd_data` = 0.
- IDLE:
  - If `as_` = 0 and `flush` = 0: register `bus_req_` = 0, latch `addr`/`rw`/`wr_data` onto the `bus_*` outputs, go to REQ.
  - `busy` = 1 combinationally in this cycle.
  - `as_` = 1 or `flush` = 1: stay in IDLE with `busy` = 0.
- REQ:
  - `busy` = 1.
  - When `bus_grant_` = 0: `bus_as_` = 0 for exactly one cycle, go to ACCESS.
  - Otherwise keep waiting with `bus_req_` held at 0.
- ACCESS:
  - `bus_as_` returns to 1.
  - While `bus_rdy_` = 1: `busy` = 1.
  - On `bus_rdy_` = 0:
    - `busy` = 0 combinationally.
    - `rd_data` = `bus_rd_data` for a read, 0 for a write.
    - `rd_buf` captures `bus_rd_data`.
    - `bus_req_` = 1.
    - Next state is STALL if `stall` = 1, else IDLE.
- STALL:
  - `busy` = 0, `rd_data` = `rd_buf`.
  - Return to IDLE when `stall` = 0.
  - A new `as_` is ignored while in STALL.
- In all states other than the ACCESS-ready cycle and STALL, `rd_data` = 0.
- `bus_addr`, `bus_rw` and `bus_wr_data` are held stable from REQ entry until return to IDLE.
- `flush` is ignored once REQ has been entered; the bus transaction always completes.

## Timing
- Minimum latency, strobe to data: 3 cycles.
  - Cycle 0: IDLE, strobe seen.
  - Cycle 1: REQ, grant seen.
  - Cycle 2: ACCESS, ready seen.
- Total `busy` cycles = 2 + grant-wait cycles + ready-wait cycles.
- `bus_as_` is a single-cycle pulse per transfer, registered.
- `bus_req_` stays low continuously from the cycle after the strobe through the cycle ready is sampled.
- Reset asserted mid-transfer: next edge forces IDLE and the reset values, abandoning the bus transaction.
- Grant and ready both low in the REQ cycle: ready is ignored; only grant is acted on.

## Configuration
- `BUS_IF_TIMEOUT_EN` defined:
  - An 8-bit counter clears on ACCESS entry and increments each ACCESS cycle with `bus_rdy_` = 1.
  - When the count reaches `TIMEOUT_CYCLES`, the transfer aborts: `bus_err` = 1 for one cycle, `busy` = 0, `rd_data` = 0, `bus_req_` = 1.
  - The next state follows the normal ready rule (STALL if `stall` = 1, else IDLE), and `rd_buf` is loaded with 0.
- Not defined:
  - No counter and no `bus_err` port.
  - ACCESS waits indefinitely for `bus_rdy_`.

## Test plan
- Read, immediate grant and ready:
  - Stimulus: `addr` = 0x0000100, `as_` = 0, `rw` = 1, `bus_rd_data` = 0xDEADBEEF.
  - Required: `busy` high 2 cycles; `rd_data` = 0xDEADBEEF in cycle 2; `bus_as_` low exactly 1 cycle.
- Write with 3 ready-wait cycles:
  - Stimulus: `wr_data` = 0x12345678, `rw` = 0.
  - Required: `bus_wr_data` = 0x12345678 and `bus_rw` = 0 held 5 cycles; `busy` high 5 cycles; `rd_data` = 0.
- Grant delayed 4 cycles:
  - Required: `bus_req_` low throughout; `bus_as_` pulses on the cycle after grant; total `busy` = 6 cycles.
- Read completes with `stall` = 1 for 3 cycles:
  - Required: STALL holds `rd_data` = `rd_buf` value 0xCAFEF00D for all 3 cycles.
  - Required: after release, return to IDLE; a concurrent `as_` = 0 is not started until IDLE.
- `flush` = 1 with `as_` = 0 in IDLE:
  - Required: no `bus_req_`, `busy` = 0.
- Reset during ACCESS:
  - Required: next cycle IDLE, `bus_req_` = 1, `busy` = 0.
- With `BUS_IF_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `bus_rdy_` never asserted:
  - Required: `bus_err` pulses 1 cycle after 4 ACCESS cycles; `rd_data` = 0; `busy` falls.
